// File: rtl/nine_segment_pkg.sv
// Shared types for the 3x3 LED matrix path: frame width, frame type and
// sequencer state encoding (also used by nine_segment_to_six_pin).
package nine_segment_pkg;

  localparam int SEG_W = 9;

  typedef logic [SEG_W-1:0] segments_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/frame_tick_timer.sv
// Frame-period timer: down-counter reloaded with TICKS-1, pulses tick on the
// enabled cycle it sits at zero, then reloads so periods run back to back.
module frame_tick_timer #(
  parameter int TICKS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= RELOAD;
    end else if (enable) begin
      count <= (count == '0) ? RELOAD : count - 1'b1;
    end
  end

endmodule

// File: rtl/nine_segment_frame_sequencer.sv
// Plays back a small buffer of 9-bit LED frames at a fixed frame rate, one-shot
// or looping, feeding the segments input of nine_segment_to_six_pin.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | output blanked, waiting for start
//   PLAY  | showing frame_idx, advancing every TICKS_PER_FRAME cycles
//   HOLD  | one-shot sequence finished, last frame left on the output
module nine_segment_frame_sequencer
  import nine_segment_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int TICKS_PER_FRAME = 50000,
  localparam int IDX_W          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  input  logic [IDX_W:0]   num_frames,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic [SEG_W-1:0] segments,
  output logic [IDX_W-1:0] frame_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  seq_state_t       state, state_n;
  segments_t        frame_buf [DEPTH];
  segments_t        segments_n;
  logic [IDX_W-1:0] frame_idx_n;
  logic [IDX_W:0]   len, len_n;
  logic             done_n;
  logic             start_ok;
  logic             is_last;
  logic             tick;
  logic             wr_ok;
  logic [IDX_W-1:0] next_idx;

  assign start_ok = start && (num_frames != '0);
  assign is_last  = (({1'b0, frame_idx}) + 1'b1) >= len;
  assign next_idx = frame_idx + 1'b1;
  assign wr_ok    = ({1'b0, wr_addr}) < DEPTH_L;
  assign busy     = (state == PLAY);

  frame_tick_timer #(
    .TICKS (TICKS_PER_FRAME)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (stop || start_ok),
    .enable (state == PLAY),
    .tick   (tick)
  );

  // Loads read frame_buf before this edge's write lands, so a same-cycle
  // write to the slot being loaded shows up only on its next load.
  always_comb begin
    state_n     = state;
    segments_n  = segments;
    frame_idx_n = frame_idx;
    len_n       = len;
    done_n      = 1'b0;

    if (stop) begin
      state_n     = IDLE;
      segments_n  = '0;
      frame_idx_n = '0;
    end else if (start_ok) begin
      state_n     = PLAY;
      segments_n  = frame_buf[0];
      frame_idx_n = '0;
      len_n       = (num_frames > DEPTH_L) ? DEPTH_L : num_frames;
    end else if (state == PLAY && tick) begin
      if (!is_last) begin
        frame_idx_n = next_idx;
        segments_n  = frame_buf[next_idx];
      end else if (loop) begin
        frame_idx_n = '0;
        segments_n  = frame_buf[0];
      end else begin
        state_n = HOLD;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      segments  <= '0;
      frame_idx <= '0;
      len       <= '0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        frame_buf[i] <= '0;
      end
    end else begin
      state     <= state_n;
      segments  <= segments_n;
      frame_idx <= frame_idx_n;
      len       <= len_n;
      done      <= done_n;
      if (wr_en && wr_ok) begin
        frame_buf[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_nine_segment_frame_sequencer.sv
// Directed bench for nine_segment_frame_sequencer with DEPTH=8, TICKS_PER_FRAME=4.
module tb_nine_segment_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [8:0] wr_data = '0;
  logic [3:0] num_frames = '0;
  logic       loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [8:0] segments;
  logic [2:0] frame_idx;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  nine_segment_frame_sequencer #(
    .DEPTH           (8),
    .TICKS_PER_FRAME (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .num_frames (num_frames),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .segments   (segments),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [2:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] n, input logic lp);
    num_frames = n; loop = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (segments !== 9'h000) begin n_err++; $display("FAIL reset_seg got %h want 000", segments); end
    n_cmp++; if (frame_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", frame_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_one_shot();
    write_slot(3'd0, 9'h1FF);
    write_slot(3'd1, 9'h155);
    write_slot(3'd2, 9'h0AA);
    n_cmp++; if (busy !== 1'b0 || segments !== 9'h000) begin n_err++; $display("FAIL idle_after_writes busy %b seg %h want 0 000", busy, segments); end
    pulse_start(4'd3, 1'b0);
    n_cmp++; if (segments !== 9'h1FF) begin n_err++; $display("FAIL os_f0_seg got %h want 1ff", segments); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL os_f0_busy got %b want 1", busy); end
    n_cmp++; if (frame_idx !== 3'd0) begin n_err++; $display("FAIL os_f0_idx got %0d want 0", frame_idx); end
    repeat (3) step();
    n_cmp++; if (segments !== 9'h1FF) begin n_err++; $display("FAIL os_f0_last_cycle got %h want 1ff", segments); end
    step();
    n_cmp++; if (segments !== 9'h155 || frame_idx !== 3'd1) begin n_err++; $display("FAIL os_f1 seg %h idx %0d want 155 1", segments, frame_idx); end
    repeat (4) step();
    n_cmp++; if (segments !== 9'h0AA || frame_idx !== 3'd2 || done !== 1'b0) begin n_err++; $display("FAIL os_f2 seg %h idx %0d done %b want 0aa 2 0", segments, frame_idx, done); end
    repeat (4) step();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL os_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL os_hold_busy got %b want 0", busy); end
    n_cmp++; if (segments !== 9'h0AA || frame_idx !== 3'd2) begin n_err++; $display("FAIL os_hold seg %h idx %0d want 0aa 2", segments, frame_idx); end
    step();
    n_cmp++; if (done !== 1'b0 || segments !== 9'h0AA || busy !== 1'b0) begin n_err++; $display("FAIL os_hold_next done %b seg %h busy %b want 0 0aa 0", done, segments, busy); end
  endtask

  task automatic test_loop();
    logic seen_done;
    seen_done = 1'b0;
    pulse_start(4'd3, 1'b1);
    n_cmp++; if (segments !== 9'h1FF) begin n_err++; $display("FAIL loop_start got %h want 1ff", segments); end
    repeat (12) begin step(); if (done) seen_done = 1'b1; end
    n_cmp++; if (segments !== 9'h1FF || frame_idx !== 3'd0 || busy !== 1'b1) begin n_err++; $display("FAIL loop_wrap seg %h idx %0d busy %b want 1ff 0 1", segments, frame_idx, busy); end
    repeat (12) begin step(); if (done) seen_done = 1'b1; end
    n_cmp++; if (segments !== 9'h1FF || frame_idx !== 3'd0 || busy !== 1'b1) begin n_err++; $display("FAIL loop_wrap2 seg %h idx %0d busy %b want 1ff 0 1", segments, frame_idx, busy); end
    n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL loop_no_done got %b want 0", seen_done); end
  endtask

  task automatic test_stop_priority();
    repeat (4) step();
    n_cmp++; if (segments !== 9'h155 || frame_idx !== 3'd1) begin n_err++; $display("FAIL stop_pre seg %h idx %0d want 155 1", segments, frame_idx); end
    stop = 1'b1; start = 1'b1; num_frames = 4'd3;
    step();
    stop = 1'b0; start = 1'b0; loop = 1'b0;
    n_cmp++; if (segments !== 9'h000 || busy !== 1'b0 || frame_idx !== 3'd0) begin n_err++; $display("FAIL stop_prio seg %h busy %b idx %0d want 000 0 0", segments, busy, frame_idx); end
    step();
    n_cmp++; if (segments !== 9'h000 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL stop_idle seg %h busy %b done %b want 000 0 0", segments, busy, done); end
  endtask

  task automatic test_length_limits();
    int n;
    pulse_start(4'd0, 1'b0);
    n_cmp++; if (busy !== 1'b0 || segments !== 9'h000) begin n_err++; $display("FAIL len0 busy %b seg %h want 0 000", busy, segments); end
    write_slot(3'd3, 9'h001);
    write_slot(3'd4, 9'h002);
    write_slot(3'd5, 9'h004);
    write_slot(3'd6, 9'h008);
    write_slot(3'd7, 9'h100);
    pulse_start(4'd12, 1'b0);
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    n_cmp++; if (n != 32) begin n_err++; $display("FAIL clamp_cycles got %0d want 32", n); end
    n_cmp++; if (segments !== 9'h100 || frame_idx !== 3'd7) begin n_err++; $display("FAIL clamp_last seg %h idx %0d want 100 7", segments, frame_idx); end
  endtask

  task automatic test_write_during_play();
    pulse_start(4'd2, 1'b0);
    n_cmp++; if (segments !== 9'h1FF) begin n_err++; $display("FAIL wp_f0 got %h want 1ff", segments); end
    write_slot(3'd1, 9'h03C);
    write_slot(3'd0, 9'h111);
    n_cmp++; if (segments !== 9'h1FF) begin n_err++; $display("FAIL wp_no_readthrough got %h want 1ff", segments); end
    repeat (2) step();
    n_cmp++; if (segments !== 9'h03C || frame_idx !== 3'd1) begin n_err++; $display("FAIL wp_f1 seg %h idx %0d want 03c 1", segments, frame_idx); end
    repeat (4) step();
    n_cmp++; if (done !== 1'b1 || segments !== 9'h03C) begin n_err++; $display("FAIL wp_done done %b seg %h want 1 03c", done, segments); end
    pulse_start(4'd1, 1'b0);
    n_cmp++; if (segments !== 9'h111 || busy !== 1'b1) begin n_err++; $display("FAIL wp_reload seg %h busy %b want 111 1", segments, busy); end
  endtask

  task automatic test_reset_mid_play();
    pulse_start(4'd3, 1'b1);
    repeat (5) step();
    n_cmp++; if (segments !== 9'h03C || busy !== 1'b1) begin n_err++; $display("FAIL rmp_pre seg %h busy %b want 03c 1", segments, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (segments !== 9'h000 || busy !== 1'b0 || frame_idx !== 3'd0 || done !== 1'b0) begin n_err++; $display("FAIL rmp_reset seg %h busy %b idx %0d done %b want 000 0 0 0", segments, busy, frame_idx, done); end
    pulse_start(4'd8, 1'b0);
    n_cmp++; if (segments !== 9'h000 || busy !== 1'b1) begin n_err++; $display("FAIL rmp_slot0 seg %h busy %b want 000 1", segments, busy); end
    for (int i = 1; i < 8; i++) begin
      repeat (4) step();
      n_cmp++; if (segments !== 9'h000 || frame_idx !== 3'(i)) begin n_err++; $display("FAIL rmp_slot%0d seg %h idx %0d want 000 %0d", i, segments, frame_idx, i); end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_one_shot();
    test_loop();
    test_stop_priority();
    test_length_limits();
    test_write_during_play();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
